// File: rtl/lcd_reset_sequencer_if.sv
// Avalon-MM master bus used by the LCD reset sequencer.
//   address     : word address (always 0, the LCD control register)
//   chipselect  : transfer request
//   write_n     : active-low write strobe
//   read_n      : active-low read strobe
//   writedata   : write data
//   readdata    : read data, valid in the cycle waitrequest is low
//   waitrequest : slave stall
interface lcd_reset_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, chipselect, write_n, read_n, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, chipselect, write_n, read_n, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/lcd_reset_sequencer.sv
// LCD reset sequencer: on start, writes 0 to the LCD control register (reset
// asserted), waits HOLD_CYCLES, writes 1 (reset released), waits
// RECOVERY_CYCLES, then reads the register back and checks bit 0.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start      : one-cycle request, accepted only in IDLE
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse on successful completion
//   error      : sticky failure flag, cleared by an accepted start or reset
//   avm        : Avalon-MM master port (zero read latency)
module lcd_reset_sequencer #(
  parameter int unsigned HOLD_CYCLES     = 50000,
  parameter int unsigned RECOVERY_CYCLES = 250000,
  parameter int unsigned WAIT_TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  lcd_reset_sequencer_if.master avm
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ASSERT, S_HOLD, S_WR_RELEASE,
    S_RECOVER, S_RD_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] RECV_LOAD = 32'(RECOVERY_CYCLES - 1);
  // Timeout fires on the WAIT_TIMEOUT-th consecutive stall cycle.
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] delay_cnt;
  logic [15:0] wait_cnt;
  logic        error_q;
  logic        bus_state;
  logic        xfer_done;
  logic        timeout;
  logic        rd_unused;

  assign bus_state = (state == S_WR_ASSERT) || (state == S_WR_RELEASE) ||
                     (state == S_RD_CHECK);
  assign xfer_done = bus_state && !avm.waitrequest;
  assign timeout   = bus_state && avm.waitrequest && (wait_cnt == WAIT_LAST);
  // Only bit 0 of the readback carries the ready status.
  assign rd_unused = ^avm.readdata[31:1];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:       if (start) state_next = S_WR_ASSERT;
      S_WR_ASSERT:  if (timeout) state_next = S_ERROR;
                    else if (xfer_done) state_next = S_HOLD;
      S_HOLD:       if (delay_cnt == 32'd0) state_next = S_WR_RELEASE;
      S_WR_RELEASE: if (timeout) state_next = S_ERROR;
                    else if (xfer_done) state_next = S_RECOVER;
      S_RECOVER:    if (delay_cnt == 32'd0) state_next = S_RD_CHECK;
      S_RD_CHECK:   if (timeout) state_next = S_ERROR;
                    else if (xfer_done) state_next = avm.readdata[0] ? S_DONE : S_ERROR;
      S_DONE:       state_next = S_IDLE;
      S_ERROR:      state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  // Delay and wait counters
  always_ff @(posedge clk) begin
    if (reset) begin
      delay_cnt <= 32'd0;
      wait_cnt  <= 16'd0;
    end else begin
      // Any state change clears the stall count, so each bus state starts at 0.
      if (state_next != state)
        wait_cnt <= 16'd0;
      else if (bus_state && avm.waitrequest)
        wait_cnt <= wait_cnt + 16'd1;

      if (state == S_WR_ASSERT && xfer_done)
        delay_cnt <= HOLD_LOAD;
      else if (state == S_WR_RELEASE && xfer_done)
        delay_cnt <= RECV_LOAD;
      else if ((state == S_HOLD || state == S_RECOVER) && delay_cnt != 32'd0)
        delay_cnt <= delay_cnt - 32'd1;
    end
  end

  // Sticky error flag: set on the way into ERROR, cleared by an accepted start
  always_ff @(posedge clk) begin
    if (reset)
      error_q <= 1'b0;
    else if (state == S_IDLE && start)
      error_q <= 1'b0;
    else if (state_next == S_ERROR && state != S_ERROR)
      error_q <= 1'b1;
  end

  // Output logic
  always_comb begin
    busy           = (state != S_IDLE);
    done           = (state == S_DONE);
    error          = error_q;
    avm.address    = 2'd0;
    avm.chipselect = 1'b0;
    avm.write_n    = 1'b1;
    avm.read_n     = 1'b1;
    avm.writedata  = 32'd0;
    case (state)
      S_WR_ASSERT: begin
        avm.chipselect = 1'b1;
        avm.write_n    = 1'b0;
      end
      S_WR_RELEASE: begin
        avm.chipselect = 1'b1;
        avm.write_n    = 1'b0;
        avm.writedata  = 32'd1;
      end
      S_RD_CHECK: begin
        avm.chipselect = 1'b1;
        avm.read_n     = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lcd_reset_sequencer.sv
module tb_lcd_reset_sequencer;
  localparam int H = 4;
  localparam int R = 6;
  localparam int T = 8;

  // Event kinds seen by the monitor
  localparam int EV_WR   = 0;
  localparam int EV_RD   = 1;
  localparam int EV_DONE = 2;
  localparam int EV_END  = 3;  // busy falling; data = error flag

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy, done, error;

  lcd_reset_sequencer_if bus();

  lcd_reset_sequencer #(
    .HOLD_CYCLES(H), .RECOVERY_CYCLES(R), .WAIT_TIMEOUT(T)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .error(error), .avm(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          at;
  } ev_t;
  ev_t expq[$];

  // Slave configuration: stall cycles per transfer and readback value
  int          stall_cfg [3];
  logic [31:0] rd_cfg;
  int          xidx = 3;
  int          used = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic got(input int kind, input logic [31:0] data, input logic [1:0] addr);
    ev_t e;
    tests++;
    if (expq.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event kind=%0d data=%0h at cycle %0d, expected nothing", kind, data, cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.data !== data || e.at != cyc || addr !== 2'd0) begin
        fails++;
        $display("FAIL event: got kind=%0d data=%0h cycle=%0d addr=%0d, expected kind=%0d data=%0h cycle=%0d addr=0",
                 kind, data, cyc, addr, e.kind, e.data, e.at);
      end
    end
  endtask

  task automatic push(input int kind, input logic [31:0] data, input int at);
    ev_t e;
    e.kind = kind; e.data = data; e.at = at;
    expq.push_back(e);
  endtask

  task automatic check_idle(input string name);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_error"}, 64'(error), 64'd0);
    chk({name, "_bus"}, {28'd0, bus.address, bus.chipselect, bus.write_n, bus.read_n, bus.writedata},
        {28'd0, 2'd0, 1'b0, 1'b1, 1'b1, 32'd0});
  endtask

  // Slave: decides waitrequest/readdata just after each edge from the new bus state
  initial begin
    bus.waitrequest = 1'b0;
    bus.readdata    = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      bus.readdata = $urandom;
      bus.waitrequest = 1'b0;
      if (bus.chipselect === 1'b1 && xidx < 3) begin
        if (used < stall_cfg[xidx]) begin
          bus.waitrequest = 1'b1;
          used++;
        end else begin
          if (bus.read_n === 1'b0) bus.readdata = rd_cfg;
          xidx++;
          used = 0;
        end
      end
    end
  end

  // Monitor: turns DUT activity into events and checks them against the queue
  initial begin
    logic        pbusy;
    logic        pstall;
    logic [63:0] pvec;
    logic [63:0] cvec;
    pbusy = 1'b0;
    pstall = 1'b0;
    pvec = 64'd0;
    forever begin
      @(negedge clk);
      cvec = {28'd0, bus.address, bus.chipselect, bus.write_n, bus.read_n, bus.writedata};
      if (pstall && bus.chipselect === 1'b1)
        chk("stall_stable", cvec, pvec);
      if (bus.chipselect === 1'b1 && bus.waitrequest === 1'b0) begin
        if (bus.read_n === 1'b0) got(EV_RD, 32'd0, bus.address);
        else                     got(EV_WR, bus.writedata, bus.address);
      end
      if (done === 1'b1) got(EV_DONE, 32'd0, 2'd0);
      if (pbusy === 1'b1 && busy === 1'b0) got(EV_END, {31'd0, error}, 2'd0);
      pbusy  = (busy === 1'b1);
      pstall = (bus.chipselect === 1'b1 && bus.waitrequest === 1'b1);
      pvec   = cvec;
    end
  end

  // One sequence run. mode 0: plain, 1: extra start during HOLD, 2: reset in RECOVER.
  task automatic run(input int s0, input int s1, input int s2, input logic [31:0] rd, input int mode);
    int s [3];
    int t, c0, a, cr, lim;
    bit ok;
    s[0] = s0; s[1] = s1; s[2] = s2;
    @(posedge clk);
    #1;
    stall_cfg[0] = s0; stall_cfg[1] = s1; stall_cfg[2] = s2;
    rd_cfg = rd; xidx = 0; used = 0;
    start = 1'b1;
    c0 = cyc;
    // Reference timeline: each phase start, its stalls, then the fixed waits
    t = c0 + 1; ok = 1'b1; a = 0; cr = 0;
    for (int i = 0; i < 3; i++) begin
      if (mode == 2 && i == 2) begin
        cr = t - R + 2;
        push(EV_END, 32'd0, cr + 1);
        ok = 1'b0;
        break;
      end
      if (s[i] >= T) begin
        push(EV_END, 32'd1, t + T + 1);
        ok = 1'b0;
        break;
      end
      push(i == 2 ? EV_RD : EV_WR, (i == 1) ? 32'd1 : 32'd0, t + s[i]);
      if (i == 0) a = t + s[i];
      t = t + s[i] + 1;
      if (i == 0) t = t + H;
      if (i == 1) t = t + R;
    end
    if (ok) begin
      if (rd[0]) begin
        push(EV_DONE, 32'd0, t);
        push(EV_END, 32'd0, t + 1);
      end else begin
        push(EV_END, 32'd1, t + 1);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_clears_error", 64'(error), 64'd0);
    chk("busy_after_start", 64'(busy), 64'd1);
    if (mode == 1) begin
      while (cyc < a + 2) begin @(posedge clk); #1; end
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    if (mode == 2) begin
      while (cyc < cr) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_idle("reset_in_recover");
    end
    lim = cyc + 200;
    while (expq.size() > 0 && cyc < lim) begin @(posedge clk); #1; end
    tests++;
    if (expq.size() > 0) begin
      fails++;
      $display("FAIL run_timeout: %0d events still pending, expected 0", expq.size());
      expq.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    rd_cfg = 32'd1;
    for (int i = 0; i < 3; i++) stall_cfg[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle("reset");

    // Clean sequence and stalled sequence
    run(0, 0, 0, 32'h1, 0);
    run(3, 3, 3, 32'h1, 0);

    // Timeout during the first write, sticky error, then recovery
    run(20, 0, 0, 32'h1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("error_sticky", 64'(error), 64'd1);
    chk("busy_after_error", 64'(busy), 64'd0);
    run(0, 0, 0, 32'h1, 0);
    chk("error_cleared", 64'(error), 64'd0);

    // Readback status bit
    run(0, 0, 0, 32'hFFFF_FFFE, 0);
    chk("readback_error", 64'(error), 64'd1);
    run(0, 0, 0, 32'h0000_0001, 0);

    // Timeouts on the later transfers, and the largest stall that still completes
    run(0, 8, 0, 32'h1, 0);
    run(0, 0, 9, 32'h1, 0);
    run(7, 7, 7, 32'h1, 0);

    // Start ignored during HOLD; reset during RECOVER
    run(0, 0, 0, 32'h1, 1);
    run(1, 2, 0, 32'h1, 2);
    check_idle("after_reset_run");

    // Randomized runs
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lcd_reset_sequencer.md
LCD_RESET_SEQUENCER -- requirements
Module: lcd_reset_sequencer

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 50000, cycles LCD reset is held low (1 ms at 50 MHz); legal range 1..2^32-1.
REQ-002 The block SHALL have parameter RECOVERY_CYCLES, default 250000, cycles waited after release before readback; legal range 1..2^32-1.
REQ-003 The block SHALL have parameter WAIT_TIMEOUT, default 255, max consecutive waitrequest cycles per bus transfer before abort; legal range 1..65535.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: clk  in  1  system clock; reset  in  1  synchronous active-high reset.
REQ-005 The block SHALL have start  in  1  one-cycle request to run the sequence.
REQ-006 The block SHALL have busy  out  1  high while the sequence runs.
REQ-007 The block SHALL have done  out  1  one-cycle pulse on successful completion.
REQ-008 The block SHALL have error  out  1  sticky failure flag.
REQ-009 The block SHALL have avm_address  out  2  Avalon-MM master word address.
REQ-010 The block SHALL have avm_chipselect  out  1  transfer request.
REQ-011 The block SHALL have avm_write_n  out  1  active-low write strobe.
REQ-012 The block SHALL have avm_read_n  out  1  active-low read strobe.
REQ-013 The block SHALL have avm_writedata  out  32  write data.
REQ-014 The block SHALL have avm_readdata  in  32  read data, valid in the cycle avm_waitrequest is low (zero read latency).
REQ-015 The block SHALL have avm_waitrequest  in  1  slave stall.

Function
REQ-016 The block SHALL implement states IDLE, WR_ASSERT, HOLD, WR_RELEASE, RECOVER, RD_CHECK, DONE, ERROR.
REQ-017 In IDLE the block SHALL move to WR_ASSERT on start=1, clearing error in the same edge; otherwise it SHALL stay in IDLE.
REQ-018 WR_ASSERT SHALL drive chipselect=1, write_n=0, read_n=1, address=0, writedata=0x00000000.
REQ-019 WR_RELEASE SHALL drive chipselect=1, write_n=0, read_n=1, address=0, writedata=0x00000001.
REQ-020 RD_CHECK SHALL drive chipselect=1, write_n=1, read_n=0, address=0.
REQ-021 A bus transfer SHALL complete on the first cycle with chipselect=1 and waitrequest=0; address, strobes and writedata SHALL stay stable until then.
REQ-022 Outside WR_ASSERT, WR_RELEASE and RD_CHECK the block SHALL drive chipselect=0, write_n=1, read_n=1, address=0, writedata=0.
REQ-023 A 16-bit wait counter SHALL clear on entry to each bus state and increment per waitrequest=1 cycle.
REQ-024 When the wait counter reaches WAIT_TIMEOUT with waitrequest still high, the block SHALL go to ERROR, deasserting chipselect on the next cycle.
REQ-025 WR_ASSERT completion SHALL go to HOLD and load a 32-bit down-counter with HOLD_CYCLES-1.
REQ-026 HOLD SHALL decrement the counter and go to WR_RELEASE in the cycle the counter is 0, giving exactly HOLD_CYCLES cycles in HOLD.
REQ-027 WR_RELEASE completion SHALL go to RECOVER and load RECOVERY_CYCLES-1; RECOVER SHALL have the same exit rule, going to RD_CHECK.
REQ-028 RD_CHECK completion SHALL sample avm_readdata[0]: 1 -> DONE, 0 -> ERROR; bits 31:1 SHALL be ignored.
REQ-029 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-030 ERROR SHALL last one cycle, set error=1, then return to IDLE; error SHALL stay 1 until the next accepted start or reset.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 start SHALL be ignored while busy=1, and while in DONE or ERROR.

Reset
REQ-033 On reset=1 at a clk edge the block SHALL enter IDLE, clear both counters, and drive busy=0, done=0, error=0, chipselect=0, write_n=1, read_n=1, address=0, writedata=0.
REQ-034 Reset mid-transfer SHALL drop chipselect in the following cycle without waiting for waitrequest, and no done pulse SHALL follow.

Verification (HOLD_CYCLES=4, RECOVERY_CYCLES=6, WAIT_TIMEOUT=8, unless stated)
REQ-035 Slave with waitrequest=0 and readdata=0x1; start pulse -> write 0x0, 4 idle cycles, write 0x1, 6 idle cycles, one read, done pulse; start to done = 14 cycles; error=0.
REQ-036 Slave stalls each transfer with waitrequest=1 for 3 cycles -> outputs stay stable during the stall; done is delayed by 9 cycles versus REQ-035.
REQ-037 waitrequest held at 1 during WR_ASSERT -> ERROR after 8 stall cycles; error=1 and busy=0 afterwards; a new start clears error.
REQ-038 readdata=0xFFFFFFFE on readback -> error=1 and no done pulse; readdata=0x00000001 -> done.
REQ-039 start re-pulsed during HOLD is ignored (exactly one write pair); reset asserted in RECOVER -> all outputs at reset values next cycle, no done pulse.
